// File: rtl/audio_tone_pkg.sv
// audio_tone_pkg: shared mode/state encodings and sine-table generation helpers
package audio_tone_pkg;
    typedef enum logic [1:0] {MODE_SILENCE, MODE_SINE, MODE_SQUARE, MODE_SAW} mode_e;
    typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_e;

    // pi/2 in Q30, the angle span of the quarter-wave table
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    function automatic longint full_scale(input int w);
        return (64'sd1 <<< (w - 1)) - 1;
    endfunction

    // Entry i of the quarter-wave table: round(full_scale * sin(pi/2 * i / (2^addr_w - 1))),
    // so entry 0 is exactly 0 and the last entry is exactly full scale.
    // Fixed-point Taylor series keeps the table a pure constant expression.
    function automatic longint sine_entry(input int i, input int addr_w, input int sample_w);
        longint x, term, sum, fs, v;
        fs = full_scale(sample_w);
        x = (HALF_PI_Q30 * i) / ((64'sd1 <<< addr_w) - 1);
        term = x;
        sum = x;
        for (int k = 1; k < 9; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / (2 * k * (2 * k + 1));
            sum += term;
        end
        v = (sum * fs + (64'sd1 <<< 29)) >>> 30;
        return v > fs ? fs : v;
    endfunction
endpackage

// File: rtl/audio_tone_if.sv
// audio_tone_if: frame output handshake towards adau_interface
// audio_out (CHANNELS*SAMPLE_W, channel 0 in LSBs), audio_valid, audio_full (back-pressure).
interface audio_tone_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 24
);
    logic [CHANNELS*SAMPLE_W-1:0] audio_out;
    logic                         audio_valid;
    logic                         audio_full;

    modport master (output audio_out, audio_valid, input audio_full);
    modport slave  (input audio_out, audio_valid, output audio_full);
endinterface

// File: rtl/sine_quarter_lut.sv
// sine_quarter_lut: registered 1-cycle quarter-wave sine magnitude ROM
// Ports: clk, addr (LUT_ADDR_W), data (SAMPLE_W-1 magnitude, valid one cycle after addr).
module sine_quarter_lut
    import audio_tone_pkg::*;
#(
    parameter int LUT_ADDR_W = 8,
    parameter int SAMPLE_W   = 24
) (
    input  logic                  clk,
    input  logic [LUT_ADDR_W-1:0] addr,
    output logic [SAMPLE_W-2:0]   data
);
    logic [SAMPLE_W-2:0] rom [2**LUT_ADDR_W];

    for (genvar i = 0; i < 2**LUT_ADDR_W; i++) begin : g_rom
        localparam logic [SAMPLE_W-2:0] V = (SAMPLE_W-1)'(sine_entry(i, LUT_ADDR_W, SAMPLE_W));
        assign rom[i] = V;
    end

    always_ff @(posedge clk)
        data <= rom[addr];
endmodule

// File: rtl/audio_tone_source.sv
// audio_tone_source: sequential multi-channel test-tone generator (silence/sine/square/saw)
// Ports: clk, reset_n (async active-low), enable, mode, phase_inc, ch_offset,
//   gain_shift (only when AUDIO_TONE_GAIN_EN is defined), busy,
//   aud (audio_tone_if.master: audio_out/audio_valid out, audio_full in).
module audio_tone_source #(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 24,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [PHASE_W-1:0] ch_offset,
`ifdef AUDIO_TONE_GAIN_EN
    input  logic [3:0]         gain_shift,
`endif
    output logic               busy,
    audio_tone_if.master       aud
);
    import audio_tone_pkg::*;

    localparam int CNT_W = $clog2(CHANNELS + 2);
    localparam logic signed [SAMPLE_W-1:0] FS = SAMPLE_W'(full_scale(SAMPLE_W));

    state_e                     state, state_n;
    mode_e                      mode_l;
    logic [CNT_W-1:0]           cnt;
    logic [PHASE_W-1:0]         acc, inc_l, off_l, ph;
    logic [SAMPLE_W-1:0]        ph1, ph2;
    logic [LUT_ADDR_W-1:0]      idx, lut_addr;
    logic [SAMPLE_W-2:0]        mag;
    logic signed [SAMPLE_W-1:0] raw, smp;
    logic                       accept, start;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;

    // FILL covers CHANNELS S0 cycles plus two cycles to drain S1/S2
    always_comb begin
        state_n = state;
        start = 1'b0;
        accept = aud.audio_valid && !aud.audio_full;
        case (state)
            IDLE: begin
                start = enable;
                state_n = enable ? FILL : IDLE;
            end
            FILL: state_n = cnt == CNT_W'(CHANNELS + 1) ? PRESENT : FILL;
            PRESENT: begin
                start = accept && enable;
                state_n = accept ? (enable ? FILL : IDLE) : PRESENT;
            end
            default: state_n = IDLE;
        endcase
    end

    assign aud.audio_valid = state == PRESENT;
    assign busy = state != IDLE;

    // ph walks acc, acc+off, acc+2*off ... one channel per FILL cycle; a frame
    // that starts on an accept begins from the already-advanced accumulator.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            acc <= '0;
            inc_l <= '0;
            off_l <= '0;
            ph <= '0;
            ph1 <= '0;
            ph2 <= '0;
            cnt <= '0;
            mode_l <= MODE_SILENCE;
        end else begin
            if (accept) acc <= acc + inc_l;
            if (start) begin
                mode_l <= mode_e'(mode);
                inc_l <= phase_inc;
                off_l <= ch_offset;
                cnt <= '0;
                ph <= accept ? acc + inc_l : acc;
            end else if (state == FILL) begin
                cnt <= cnt + 1'b1;
                ph <= ph + off_l;
            end
            ph1 <= ph[PHASE_W-1 -: SAMPLE_W];
            ph2 <= ph1;
        end

    // Quadrants 1 and 3 read the table backwards
    assign idx = ph1[SAMPLE_W-3 -: LUT_ADDR_W];
    assign lut_addr = ph1[SAMPLE_W-2] ? ~idx : idx;

    sine_quarter_lut #(.LUT_ADDR_W(LUT_ADDR_W), .SAMPLE_W(SAMPLE_W)) u_lut (
        .clk (clk),
        .addr(lut_addr),
        .data(mag)
    );

    assign raw = mode_l == MODE_SINE   ? (ph2[SAMPLE_W-1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag})) :
                 mode_l == MODE_SQUARE ? (ph2[SAMPLE_W-1] ? -FS : FS) :
                 mode_l == MODE_SAW    ? $signed({~ph2[SAMPLE_W-1], ph2[SAMPLE_W-2:0]}) : '0;

`ifdef AUDIO_TONE_GAIN_EN
    logic [3:0] gain_l;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) gain_l <= '0;
        else if (start) gain_l <= gain_shift;

    assign smp = raw >>> gain_l;
`else
    assign smp = raw;
`endif

    // Channel c leaves S2 in FILL cycle c+2
    for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
        logic signed [SAMPLE_W-1:0] slot;

        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) slot <= '0;
            else if (state == FILL && cnt == CNT_W'(c + 2)) slot <= smp;

        assign aud.audio_out[c*SAMPLE_W +: SAMPLE_W] = slot;
    end
endmodule

// File: tb/tb_audio_tone_source.sv
// tb_audio_tone_source: scoreboard bench for audio_tone_source
module tb_audio_tone_source;
    localparam int CH  = 2;
    localparam int SW  = 24;
    localparam int PW  = 32;
    localparam int LA  = 8;
    localparam int FSV = (1 << (SW - 1)) - 1;

    typedef struct {
        logic [CH*SW-1:0] f;
        bit               tol;
    } exp_t;

    typedef struct {
        logic [1:0]    m;
        logic [PW-1:0] inc;
        logic [PW-1:0] off;
        int            n;
    } vec_t;

    logic          clk = 0;
    logic          reset_n = 0;
    logic          enable = 0;
    logic [1:0]    mode = 0;
    logic [PW-1:0] phase_inc = 0;
    logic [PW-1:0] ch_offset = 0;
    logic [3:0]    gain_shift = 0;
    logic          busy;

    audio_tone_if #(.CHANNELS(CH), .SAMPLE_W(SW)) aif ();

    audio_tone_source #(.CHANNELS(CH), .SAMPLE_W(SW), .PHASE_W(PW), .LUT_ADDR_W(LA)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .mode     (mode),
        .phase_inc(phase_inc),
        .ch_offset(ch_offset),
`ifdef AUDIO_TONE_GAIN_EN
        .gain_shift(gain_shift),
`endif
        .busy     (busy),
        .aud      (aif.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t          q[$];
    int            acc_cyc[$];
    int            total = 0;
    int            bad = 0;
    int            n_acc = 0;
    logic [PW-1:0] exp_acc = 0;
    vec_t          vt[6];

    function automatic logic signed [SW-1:0] model(input logic [1:0] m, input logic [PW-1:0] p, input logic [3:0] g);
        logic signed [SW-1:0] v;
        int i;
        real r;
        case (m)
            2'd1: begin
                i = int'(p[PW-3 -: LA]);
                if (p[PW-2]) i = (1 << LA) - 1 - i;
                r = FSV * $sin(3.14159265358979 / 2.0 * i / ((1 << LA) - 1));
                v = SW'($rtoi(r + 0.5));
                if (p[PW-1]) v = -v;
            end
            2'd2: v = p[PW-1] ? SW'(-FSV) : SW'(FSV);
            2'd3: v = {~p[PW-1], p[PW-2 -: SW-1]};
            default: v = '0;
        endcase
        return v >>> g;
    endfunction

    function automatic logic [CH*SW-1:0] frame_of(input logic [PW-1:0] a);
        logic [CH*SW-1:0] f;
        logic [PW-1:0] p;
        p = a;
        for (int k = 0; k < CH; k++) begin
            f[k*SW +: SW] = model(mode, p, gain_shift);
            p = p + ch_offset;
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic push_frames(input int k, input bit tol);
        for (int i = 0; i < k; i++) begin
            q.push_back('{frame_of(exp_acc), tol});
            exp_acc = exp_acc + phase_inc;
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic [SW-1:0] a, x;
        int d;
        forever begin
            @(negedge clk);
            if (reset_n && aif.audio_valid && !aif.audio_full) begin
                n_acc++;
                acc_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %h want none", aif.audio_out);
                end else begin
                    e = q.pop_front();
                    for (int c = 0; c < CH; c++) begin
                        a = aif.audio_out[c*SW +: SW];
                        x = e.f[c*SW +: SW];
                        d = int'($signed(a)) - int'($signed(x));
                        total++;
                        if (e.tol ? (d > 1 || d < -1) : (d != 0)) begin
                            bad++;
                            $display("FAIL frame%0d_ch%0d: got %0d want %0d", n_acc, c, $signed(a), $signed(x));
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_acc(input int t);
        for (int i = 0; i < 1000 && n_acc < t; i++) tick();
        check("accept_wait", n_acc >= t, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick();
        check("idle", busy, 0);
    endtask

    task automatic stream(input int k, input bit tol);
        int base;
        push_frames(k, tol);
        base = n_acc;
        enable = 1;
        if (k > 1) wait_acc(base + k - 1);
        else tick();
        enable = 0;
        wait_idle();
        check("frame_count", n_acc - base, k);
    endtask

    initial begin
        int base, lat, changes;
        logic [CH*SW-1:0] snap;
        vt[0] = '{2'd2, 32'h2000_0000, 32'h8000_0000, 10};
        vt[1] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0100, 4};
        vt[2] = '{2'd3, 32'hFFFF_FF00, 32'h0000_0000, 3};
        vt[3] = '{2'd1, 32'h0123_4567, 32'h4000_0000, 5};
        vt[4] = '{2'd0, 32'h1000_0000, 32'h1234_5678, 2};
        vt[5] = '{2'd1, 32'h0000_0000, 32'h0800_0000, 3};
        aif.audio_full = 0;
        fork
            monitor();
        join_none

        // reset state
        tick();
        tick();
        check("rst_valid", aif.audio_valid, 0);
        check("rst_out", aif.audio_out, 0);
        check("rst_busy", busy, 0);
        reset_n = 1;
        tick();

        // sine quarter points, latency and throughput from a fresh accumulator
        reset_n = 0;
        tick();
        reset_n = 1;
        exp_acc = 0;
        mode = 2'd1;
        phase_inc = 32'h4000_0000;
        ch_offset = 0;
        push_frames(8, 0);
        base = n_acc;
        acc_cyc.delete();
        enable = 1;
        lat = 0;
        while (lat < 20 && !aif.audio_valid) begin
            tick();
            lat++;
        end
        check("latency", lat, CH + 3);
        wait_acc(base + 7);
        enable = 0;
        wait_idle();
        check("frame_count", n_acc - base, 8);
        for (int i = 1; i < acc_cyc.size(); i++) check("throughput", acc_cyc[i] - acc_cyc[i-1], CH + 3);

        // table of waveform/frequency/offset vectors
        for (int i = 0; i < 6; i++) begin
            mode = vt[i].m;
            phase_inc = vt[i].inc;
            ch_offset = vt[i].off;
            stream(vt[i].n, vt[i].m == 2'd1);
        end

        // back-pressure: frame held for 50 cycles, then the stream resumes in order
        mode = 2'd3;
        phase_inc = 32'h0300_0000;
        ch_offset = 32'h0001_0000;
        push_frames(6, 0);
        base = n_acc;
        enable = 1;
        wait_acc(base + 2);
        aif.audio_full = 1;
        for (int i = 0; i < 20 && !aif.audio_valid; i++) tick();
        check("hold_valid", aif.audio_valid, 1);
        snap = aif.audio_out;
        changes = 0;
        repeat (50) begin
            tick();
            if (aif.audio_out !== snap || aif.audio_valid !== 1'b1) changes++;
        end
        check("hold_stable", changes, 0);
        check("hold_no_accept", n_acc - base, 2);
        aif.audio_full = 0;
        wait_acc(base + 5);
        enable = 0;
        wait_idle();
        check("frame_count", n_acc - base, 6);

        // asynchronous reset in the middle of FILL
        mode = 2'd2;
        phase_inc = 32'h1000_0000;
        ch_offset = 32'h4000_0000;
        enable = 1;
        tick();
        enable = 0;
        repeat (3) tick();
        check("fill_slot0_written", aif.audio_out != 0, 1);
        #2 reset_n = 0;
        #1;
        check("async_valid", aif.audio_valid, 0);
        check("async_out", aif.audio_out, 0);
        check("async_busy", busy, 0);
        tick();
        reset_n = 1;
        exp_acc = 0;
        stream(2, 0);

`ifdef AUDIO_TONE_GAIN_EN
        // gain changed mid-frame applies from the next frame
        mode = 2'd2;
        phase_inc = 32'h8000_0000;
        ch_offset = 32'h4000_0000;
        gain_shift = 0;
        q.push_back('{frame_of(exp_acc), 1'b0});
        exp_acc = exp_acc + phase_inc;
        gain_shift = 3;
        q.push_back('{frame_of(exp_acc), 1'b0});
        exp_acc = exp_acc + phase_inc;
        gain_shift = 0;
        base = n_acc;
        enable = 1;
        tick();
        tick();
        gain_shift = 3;
        wait_acc(base + 1);
        enable = 0;
        wait_idle();
        check("gain_frame_count", n_acc - base, 2);
        gain_shift = 0;
`endif

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
